// File: rtl/cond_eval_pkg.sv
// Shared constants for the condition unit: ARM condition codes and NZCV bit positions.
package cond_eval_pkg;

    typedef enum logic [3:0] {
        CC_EQ = 4'b0000, CC_NE = 4'b0001, CC_CS = 4'b0010, CC_CC = 4'b0011,
        CC_MI = 4'b0100, CC_PL = 4'b0101, CC_VS = 4'b0110, CC_VC = 4'b0111,
        CC_HI = 4'b1000, CC_LS = 4'b1001, CC_GE = 4'b1010, CC_LT = 4'b1011,
        CC_GT = 4'b1100, CC_LE = 4'b1101, CC_AL = 4'b1110, CC_NV = 4'b1111
    } cond_code_e;

    localparam int V_BIT = 3;
    localparam int C_BIT = 2;
    localparam int Z_BIT = 1;
    localparam int N_BIT = 0;

endpackage

// File: rtl/cond_eval_lane.sv
// Single-lane combinational condition evaluator: code + NZCV flags -> pass.
module cond_eval_lane
    import cond_eval_pkg::*;
(
    input  logic [3:0] code,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[N_BIT];
    assign z = flags[Z_BIT];
    assign c = flags[C_BIT];
    assign v = flags[V_BIT];

    always_comb begin
        pass = 1'b0;
        case (cond_code_e'(code))
            CC_EQ: pass = z;
            CC_NE: pass = ~z;
            CC_CS: pass = c;
            CC_CC: pass = ~c;
            CC_MI: pass = n;
            CC_PL: pass = ~n;
            CC_VS: pass = v;
            CC_VC: pass = ~v;
            CC_HI: pass = c & ~z;
            CC_LS: pass = ~c | z;
            CC_GE: pass = ~(n ^ v);
            CC_LT: pass = n ^ v;
            CC_GT: pass = ~z & ~(n ^ v);
            CC_LE: pass = z | (n ^ v);
            CC_AL: pass = 1'b1;
            CC_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_eval_unit.sv
// Architectural NZCV register with same-cycle forwarding and LANES-wide condition evaluation.
module cond_eval_unit
    import cond_eval_pkg::*;
#(
    parameter int         LANES    = 2,
    parameter int         OUT_REG  = 1,
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flag_we,
    input  logic [3:0]         flag_in,
    input  logic [3:0]         flag_mask,
    input  logic [4*LANES-1:0] code,
    input  logic [LANES-1:0]   code_valid,
    input  logic               stall,
    input  logic               flush,
    output logic [LANES-1:0]   cond,
    output logic [LANES-1:0]   cond_valid,
    output logic [3:0]         flags_q
);

    logic             flag_wr;
    logic [3:0]       flags_merged;
    logic [3:0]       flags_fwd;
    logic [LANES-1:0] raw;
    logic [LANES-1:0] eval;

    // Flush is deliberately absent here: the flag writer is older than anything being flushed.
    assign flag_wr      = flag_we & ~stall;
    assign flags_merged = (flags_q & ~flag_mask) | (flag_in & flag_mask);
    assign flags_fwd    = flag_wr ? flags_merged : flags_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     flags_q <= FLAG_RST;
        else if (flag_wr) flags_q <= flags_merged;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cond_eval_lane u_lane (
            .code  (code[4*i +: 4]),
            .flags (flags_fwd),
            .pass  (raw[i])
        );
    end

    assign eval = raw & code_valid;

    if (OUT_REG != 0) begin : g_oreg
        logic [LANES-1:0] cond_r;
        logic [LANES-1:0] cond_valid_r;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cond_r       <= '0;
                cond_valid_r <= '0;
            end else if (flush) begin
                cond_r       <= '0;
                cond_valid_r <= '0;
            end else if (!stall) begin
                cond_r       <= eval;
                cond_valid_r <= code_valid;
            end
        end

        assign cond       = cond_r;
        assign cond_valid = cond_valid_r;
    end else begin : g_ocomb
        assign cond       = eval & {LANES{~flush}};
        assign cond_valid = code_valid & {LANES{~flush}};
    end

endmodule

// File: tb/tb_cond_eval_unit.sv
// Bench for cond_eval_unit: registered and combinational instances against an NZCV model.
module tb_cond_eval_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       flag_we;
    logic [3:0] flag_in, flag_mask;
    logic [7:0] code;
    logic [1:0] code_valid;
    logic       stall, flush;
    logic [1:0] cond_r, valid_r, cond_c, valid_c;
    logic [3:0] flags_r, flags_c;

    int total = 0;
    int bad   = 0;

    logic [3:0] mflags;
    logic [1:0] mcond, mvalid;

    always #5 clk = ~clk;

    cond_eval_unit #(.LANES(2), .OUT_REG(1), .FLAG_RST(4'b0000)) u_reg (
        .clk(clk), .reset_n(reset_n), .flag_we(flag_we), .flag_in(flag_in),
        .flag_mask(flag_mask), .code(code), .code_valid(code_valid), .stall(stall),
        .flush(flush), .cond(cond_r), .cond_valid(valid_r), .flags_q(flags_r)
    );

    cond_eval_unit #(.LANES(2), .OUT_REG(0), .FLAG_RST(4'b0000)) u_comb (
        .clk(clk), .reset_n(reset_n), .flag_we(flag_we), .flag_in(flag_in),
        .flag_mask(flag_mask), .code(code), .code_valid(code_valid), .stall(stall),
        .flush(flush), .cond(cond_c), .cond_valid(valid_c), .flags_q(flags_c)
    );

    typedef struct {
        logic       we;
        logic [3:0] fin;
        logic [3:0] mask;
        logic [7:0] code;
        logic [1:0] cv;
        logic       st;
        logic       fl;
        logic [1:0] exp_cond;
        logic [1:0] exp_valid;
        logic [3:0] exp_flags;
    } vec_t;

    vec_t vecs[9];

    // Codes pair up as predicate / inverse; 111x is "always" with NV as its inverse.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, p;
        n = f[0]; z = f[1]; cy = f[2]; v = f[3];
        case (c[3:1])
            3'd0: p = z;
            3'd1: p = cy;
            3'd2: p = n;
            3'd3: p = v;
            3'd4: p = cy && !z;
            3'd5: p = (n == v);
            3'd6: p = !z && (n == v);
            default: p = 1'b1;
        endcase
        return p ^ c[0];
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] fin, input logic [3:0] mask,
                         input logic [7:0] cd, input logic [1:0] cv, input logic st,
                         input logic fl);
        flag_we = we; flag_in = fin; flag_mask = mask;
        code = cd; code_valid = cv; stall = st; flush = fl;
    endtask

    // Checks combinational outputs, crosses one rising edge, then checks registered state.
    task automatic step();
        logic [3:0] f;
        logic [1:0] ev;
        #1;
        f = (flag_we && !stall) ? ((mflags & ~flag_mask) | (flag_in & flag_mask)) : mflags;
        for (int i = 0; i < 2; i++) ev[i] = ref_cond(code[4*i +: 4], f) & code_valid[i];
        chk("comb_cond",  {6'd0, cond_c},  {6'd0, flush ? 2'b00 : ev});
        chk("comb_valid", {6'd0, valid_c}, {6'd0, flush ? 2'b00 : code_valid});
        @(posedge clk);
        mflags = f;
        if (flush) begin
            mcond = 2'b00; mvalid = 2'b00;
        end else if (!stall) begin
            mcond = ev; mvalid = code_valid;
        end
        #1;
        chk("reg_cond",   {6'd0, cond_r},  {6'd0, mcond});
        chk("reg_valid",  {6'd0, valid_r}, {6'd0, mvalid});
        chk("reg_flags",  {4'd0, flags_r}, {4'd0, mflags});
        chk("comb_flags", {4'd0, flags_c}, {4'd0, mflags});
    endtask

    initial begin
        //                we   fin      mask     code   cv     st fl  cond   valid  flags
        vecs[0] = '{1'b0, 4'h0, 4'h0, 8'hE0, 2'b11, 1'b0, 1'b0, 2'b10, 2'b11, 4'b0000};
        vecs[1] = '{1'b1, 4'h2, 4'hF, 8'hF0, 2'b01, 1'b0, 1'b0, 2'b01, 2'b01, 4'b0010};
        vecs[2] = '{1'b1, 4'hF, 4'hF, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 4'b1111};
        vecs[3] = '{1'b1, 4'h0, 4'h3, 8'hA8, 2'b11, 1'b0, 1'b0, 2'b01, 2'b11, 4'b1100};
        vecs[4] = '{1'b0, 4'h0, 4'h0, 8'hEB, 2'b11, 1'b0, 1'b0, 2'b11, 2'b11, 4'b1100};
        vecs[5] = '{1'b1, 4'h1, 4'hF, 8'h00, 2'b00, 1'b1, 1'b0, 2'b11, 2'b11, 4'b1100};
        vecs[6] = '{1'b1, 4'h1, 4'hF, 8'h00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 4'b1100};
        vecs[7] = '{1'b1, 4'h5, 4'h0, 8'h10, 2'b10, 1'b0, 1'b0, 2'b10, 2'b10, 4'b1100};
        vecs[8] = '{1'b1, 4'h1, 4'h1, 8'hEE, 2'b11, 1'b0, 1'b1, 2'b00, 2'b00, 4'b1101};

        reset_n = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 8'h00, 2'b00, 1'b0, 1'b0);
        mflags = 4'b0000; mcond = 2'b00; mvalid = 2'b00;
        #12;
        chk("rst_flags", {4'd0, flags_r}, 8'h00);
        chk("rst_cond",  {6'd0, cond_r},  8'h00);
        chk("rst_valid", {6'd0, valid_r}, 8'h00);
        reset_n = 1'b1;

        for (int k = 0; k < 9; k++) begin
            drive(vecs[k].we, vecs[k].fin, vecs[k].mask, vecs[k].code, vecs[k].cv,
                  vecs[k].st, vecs[k].fl);
            step();
            chk("vec_cond",  {6'd0, cond_r},  {6'd0, vecs[k].exp_cond});
            chk("vec_valid", {6'd0, valid_r}, {6'd0, vecs[k].exp_valid});
            chk("vec_flags", {4'd0, flags_r}, {4'd0, vecs[k].exp_flags});
        end

        // Every flag value forwarded into every code on both lanes.
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                logic [3:0] cc;
                cc = c[3:0];
                drive(1'b1, f[3:0], 4'hF, {~cc, cc}, 2'b11, 1'b0, 1'b0);
                step();
            end
        end

        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom), 4'($urandom), 4'($urandom), 8'($urandom), 2'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
            step();
        end

        // Asynchronous reset landing mid-cycle with live outputs.
        drive(1'b1, 4'b1010, 4'hF, 8'hEE, 2'b11, 1'b0, 1'b0);
        step();
        chk("pre_rst_cond", {6'd0, cond_r}, 8'h03);
        drive(1'b0, 4'h0, 4'h0, 8'hEE, 2'b11, 1'b1, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_flags",  {4'd0, flags_r}, 8'h00);
        chk("arst_flagsc", {4'd0, flags_c}, 8'h00);
        chk("arst_cond",   {6'd0, cond_r},  8'h00);
        chk("arst_valid",  {6'd0, valid_r}, 8'h00);
        mflags = 4'b0000; mcond = 2'b00; mvalid = 2'b00;
        #2;
        reset_n = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 8'hE0, 2'b11, 1'b0, 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cond_eval_unit.md
Name: cond_eval_unit

Overview:
- Next-generation condition unit: owns the architectural NZCV flag register and evaluates the ARM condition field for LANES instructions per cycle.
- Sits between the EX stage, which writes the flags, and the ID/EX boundary, which needs each instruction's pass/fail result.
- Adds the following: a registered flag state, per-bit flag update masking, same-cycle flag forwarding, an NV (never) code, multi-lane evaluation, and a registered output stage with stall and flush.

Parameters:
- LANES, 2, number of condition codes evaluated per cycle (1..4).
- OUT_REG, 1, 1 = registered outputs (latency 1); 0 = combinational outputs (latency 0).
- FLAG_RST, 4'b0000, reset value of the flag register.

Ports:
- Clk, input, 1, rising-edge clock.
- Reset_n, input, 1, asynchronous active-low reset.
- Flag_we, input, 1, flag write request from EX (S-bit instruction).
- Flag_in, input, 4, new flags; [3]=V, [2]=C, [1]=Z, [0]=N.
- Flag_mask, input, 4, per-bit write enable, same bit order as Flag_in.
- Code, input, 4*LANES, condition field per lane; lane i occupies [4i+3:4i].
- Code_valid, input, LANES, lane i carries a real instruction.
- Stall, input, 1, freeze flags and output stage.
- Flush, input, 1, kill output results.
- Cond, output, LANES, condition passed per lane.
- Cond_valid, output, LANES, lane result is meaningful.
- Flags_q, output, 4, current architectural flags.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - Flags_q = FLAG_RST.
  - Cond = 0 and Cond_valid = 0 when OUT_REG=1.
  - Release is synchronous to the next Clk edge.
- Flag update, at the clock edge when Flag_we=1 and Stall=0:
  - Flags_q <= (Flags_q & ~Flag_mask) | (Flag_in & Flag_mask).
  - Flag_mask=0 leaves the flags unchanged.
  - Stall=1 blocks the write; EX holds its request until Stall deasserts.
- Forwarding:
  - Effective flags F = the masked merge of Flag_in into Flags_q when Flag_we=1 and Stall=0; otherwise F = Flags_q.
  - Every lane evaluates against F, so an instruction directly after a flag setter sees the new flags with no bubble.
- Condition table, applied to F:
  - 0000 EQ: Z.
  - 0001 NE: !Z.
  - 0010 CS: C.
  - 0011 CC: !C.
  - 0100 MI: N.
  - 0101 PL: !N.
  - 0110 VS: V.
  - 0111 VC: !V.
  - 1000 HI: C & !Z.
  - 1001 LS: !C | Z.
  - 1010 GE: N==V.
  - 1011 LT: N!=V.
  - 1100 GT: !Z & (N==V).
  - 1101 LE: Z | (N!=V).
  - 1110 AL: 1.
  - 1111 NV: 0.
  - Each lane's raw result is anded with its Code_valid bit.
- Output stage, OUT_REG=1, priority order:
  - Flush=1: Cond <= 0, Cond_valid <= 0. Flush beats Stall.
  - Else Stall=1: hold Cond and Cond_valid.
  - Else: Cond <= eval & Code_valid, Cond_valid <= Code_valid.
- Output stage, OUT_REG=0:
  - Cond = eval & Code_valid & ~Flush.
  - Cond_valid = Code_valid & ~Flush.
  - Stall has no effect on outputs.
- Flush does not gate the flag write: the writer is older than the flushed instructions. Flush=1 with Stall=1 clears the outputs and holds the flags.
- Lanes are independent; all lanes share one F, with no intra-bundle flag dependency.
- Reset asserted mid-stall or mid-flush forces the reset values immediately.

Decomposition:
- Shared package:
  - Condition code constants (EQ..AL, NV).
  - Flag bit index constants V_BIT=3, C_BIT=2, Z_BIT=1, N_BIT=0.
- Sub-module cond_eval_lane: a purely combinational evaluator (4-bit code, 4-bit flags -> 1-bit pass), instantiated LANES times via generate.
- The top level holds the flag register, the forwarding mux and the output register.

Test Plan:
1. Reset: hold Reset_n=0 with FLAG_RST=4'b0000 -> Flags_q=0000, Cond=00, Cond_valid=00. Then Code={AL,EQ}, valid=11 -> next cycle Cond=10 (lane1 AL=1, lane0 EQ=0), Cond_valid=11.
2. Forwarding: Flags_q=0000; Flag_we=1, Flag_in=0010 (Z), mask=1111; same cycle Code lane0=EQ, valid=01 -> next edge Cond[0]=1 and Flags_q=0010.
3. Masked write: Flags_q=1111; Flag_we=1, Flag_in=0000, mask=0011 -> Flags_q=1100. Then evaluate HI -> 1 (C=1, Z=0), GE -> 0 (N=0, V=1), LT -> 1.
4. Stall then Flush: Cond=11 registered; Stall=1 with Flag_we=1, Flag_in=0001, mask=1111 -> Cond holds 11 and Flags_q is unchanged. Raise Flush=1 with Stall=1 -> next edge Cond_valid=00 and flags still unchanged.
5. Exhaustive table: sweep all 16 codes × 16 flag values on each lane against a reference model -> NV always 0, AL always 1, zero mismatches. Repeat with OUT_REG=0, checking zero latency and that Flush forces Cond=0 the same cycle.
6. Async reset: assert Reset_n=0 mid-cycle while Cond=11 and Flags_q=1010 -> outputs zero and Flags_q=FLAG_RST before the next Clk edge.
